// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_pkg: shared constants, FSM state type and sizing helper for the   |
// | sequential binary-to-BCD converter.              Rev 1.0             |
// +----------------------------------------------------------------------+
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Decimal digits needed for 2^width-1, i.e. ceil(width*log10(2)); 2^w is never a power of ten.
  function automatic int min_digits(input int width);
    int d;
    d = (width * 30103 + 99999) / 100000;
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_adj: one double-dabble correction step, +3 when digit >= 5. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  output logic [BCD_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
  end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin_to_bcd_seq: iterative shift-and-add-3 binary-to-BCD converter     |
// | with start/busy/done handshake and optional two's-complement input.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_W-1:0]           bin_in,
  input  logic                      signed_mode,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      neg_out
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

  generate
    if (IN_W < 2 || DIGITS < min_digits(IN_W)) begin : g_param_bad
      $fatal(1, "bin_to_bcd_seq: IN_W must be >= 2 and DIGITS large enough for 2^IN_W-1");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    mag_q, mag_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [SCR_W-1:0]   scr_adj;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               neg_out_q, neg_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               take_neg;
  logic [IN_W-1:0]    mag_in;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
      bcd_digit_adj u_adj (
        .digit_in  (scr_q[gi*BCD_W +: BCD_W]),
        .digit_out (scr_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  always_comb begin
    // Negation modulo 2^IN_W yields 2^(IN_W-1) for the most-negative operand, which fits unsigned.
    take_neg  = signed_mode & bin_in[IN_W-1];
    mag_in    = take_neg ? (~bin_in + 1'b1) : bin_in;

    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    scr_d     = scr_q;
    neg_d     = neg_q;
    bcd_d     = bcd_q;
    neg_out_d = neg_out_q;

    case (state_q)
      ST_SHIFT: begin
        {scr_d, mag_d} = {scr_adj, mag_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d   = ST_DONE;
          bcd_d     = scr_d;
          neg_out_d = neg_q;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_SHIFT;
          mag_d   = mag_in;
          neg_d   = take_neg;
          scr_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mag_q     <= '0;
      scr_q     <= '0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      neg_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      scr_q     <= scr_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
      neg_out_q <= neg_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg_out = neg_out_q;

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Iterative (shift-and-add-3 / double-dabble) binary-to-BCD converter with a start/busy/done handshake.
- Next-generation replacement for the fixed 8-bit combinational converter.
- Generalised in input width and digit count, with an optional two's-complement mode.
- Used by ALU result display paths: the ALU result feeds this block, and its BCD digits drive the 7-segment decoders.

Parameters:
IN_W, 8, binary input width (>= 2)
DIGITS, 3, number of BCD digits out; must satisfy 10^DIGITS > 2^IN_W - 1 (elaboration-time check, fatal if violated)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request conversion; sampled only when busy=0
bin_in  input  IN_W  operand, captured on accepted start
signed_mode  input  1  captured with bin_in; 1 = treat bin_in as two's complement
busy  output  1  high while iterations run
done  output  1  one-cycle pulse, result valid
bcd_out  output  4*DIGITS  packed digits, [3:0] = units, [7:4] = tens, ...
neg_out  output  1  sign of last result (1 only if signed_mode and bin_in MSB=1)

Behaviour:
Reset (rst=1 at a rising edge):
- state=IDLE; busy=0; done=0; bcd_out=0; neg_out=0; iteration counter=0.
- Reset mid-conversion aborts immediately, with no done pulse.
- rst has priority over start.

FSM states: IDLE, SHIFT, DONE.
- busy = (state==SHIFT).
- done = (state==DONE).

IDLE or DONE, start=1 at edge k:
- Capture magnitude: mag = (signed_mode && bin_in[IN_W-1]) ? -bin_in : bin_in, computed in IN_W+1 bits. Most-negative input (e.g. -128 for IN_W=8) gives magnitude 2^(IN_W-1), which must convert correctly.
- Capture sign into an internal neg register.
- Clear the BCD scratch register; counter=0; state->SHIFT.

SHIFT, each edge performs one iteration:
- Every scratch digit >= 5 gets +3 (combinational).
- Then shift {scratch, mag} left by 1.
- counter++.
- On the edge completing iteration IN_W, state->DONE, and bcd_out and neg_out load from scratch and neg.

Latency and output behaviour:
- Start accepted at edge k gives done=1 in the cycle after edge k+IN_W, i.e. IN_W cycles.
- bcd_out/neg_out hold the previous result during a conversion; they change only at completion.

DONE lasts one cycle:
- start=1 then → new capture, state->SHIFT (back-to-back supported, throughput IN_W+1 cycles).
- Otherwise → IDLE.

Boundary conditions:
- start while busy=1 is ignored; bin_in/signed_mode changes during SHIFT have no effect.
- bin_in=0 → bcd_out=0, neg_out=0.
- signed_mode=1 with a non-negative operand → neg_out=0.
- Unused digit bits are never written above 9; each digit is always 0..9.
- The counter is sized $clog2(IN_W+1) and does not wrap within a conversion.

Decomposition:
Package bcd_pkg:
- BCD_W=4 constant.
- State enum (IDLE/SHIFT/DONE).
- Function min_digits(width) used for the parameter check.

Sub-module bcd_digit_adj:
- Combinational 4-bit "if >=5 add 3".
- Instantiated DIGITS times in a generate loop.

Test Plan:
- IN_W=8, bin_in=255, signed_mode=0, start pulse → done exactly 8 cycles later; bcd_out=12'h255, neg_out=0.
- bin_in=8'h80, signed_mode=1 → bcd_out=12'h128, neg_out=1. Also bin_in=8'hFF, signed_mode=1 → 12'h001, neg_out=1.
- start with 42, then start with 99 held during busy → single done; bcd_out=12'h042. Next start gives 12'h099. During the second conversion bcd_out stays 12'h042 until done.
- Back-to-back: start asserted in the done cycle with 7 → second done 9 cycles after the first; bcd_out=12'h007. bin_in=0 → 12'h000.
- rst=1 at the 4th SHIFT cycle → next cycle busy=0, done=0, bcd_out=0; no done pulse ever appears for that operation.
- IN_W=16, DIGITS=5: bin_in=65535 → bcd_out=20'h65535 after 16 cycles. Exhaustive sweep 0..255 (IN_W=8, both modes) against a reference model.
